approx_mult_error_monitor: RTL and testbench

//  Sits directly downstream of multiplier_8x8_struct. Consumes each 8x8 operand pair and the

---
 rtl/approx_mult_error_monitor.sv | 139 +++++++++++++
 tb/tb_approx_mult_error_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_error_monitor.sv
// Error monitor for an approximate 8x8 multiplier: compares each approximate product with the
// exact one and accumulates error distance, error count and the worst-case error over a run.
module approx_mult_error_monitor #(
    parameter int unsigned SAMPLE_CNT = 256,
    parameter int unsigned SUM_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [15:0]      approx_prod,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SUM_W-1:0] sum_ed,
    output logic [15:0]      err_count,
    output logic [15:0]      max_ed,
    output logic [7:0]       max_a,
    output logic [7:0]       max_b,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(SAMPLE_CNT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_cnt;
    logic             r_s1_valid;
    logic [15:0]      r_s1_exact;
    logic [15:0]      r_s1_approx;
    logic [7:0]       r_s1_a;
    logic [7:0]       r_s1_b;

    logic             w_accept;
    logic             w_clear;
    logic [15:0]      w_exact;
    logic [15:0]      w_ed;
    logic [SUM_W:0]   w_sum_ext;
    logic [SUM_W-1:0] w_sum_next;

    assign w_accept = in_valid & in_ready;
    assign w_exact  = 16'(a) * 16'(b);

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next  = RUN;
                    w_clear = 1'b1;
                end
            end
            RUN: begin
                if (w_accept && (r_cnt == LAST_IDX)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: w_next = DONE;
            DONE: begin
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Stage 2: error distance and a saturating accumulate (the carry-out selects all-ones).
    always_comb begin
        w_ed       = (r_s1_exact >= r_s1_approx) ? (r_s1_exact - r_s1_approx)
                                                 : (r_s1_approx - r_s1_exact);
        w_sum_ext  = {1'b0, sum_ed} + (SUM_W+1)'(w_ed);
        w_sum_next = w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            res_valid   <= 1'b0;
            r_cnt       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_exact  <= '0;
            r_s1_approx <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            sum_ed      <= '0;
            err_count   <= '0;
            max_ed      <= '0;
            max_a       <= '0;
            max_b       <= '0;
        end else begin
            r_state    <= w_next;
            // Handshake flags are decoded from the next state so they are pure registers.
            busy       <= (w_next == RUN) || (w_next == DRAIN);
            in_ready   <= (w_next == RUN);
            res_valid  <= (w_next == DONE);
            r_s1_valid <= w_accept;

            if (w_accept) begin
                r_s1_exact  <= w_exact;
                r_s1_approx <= approx_prod;
                r_s1_a      <= a;
                r_s1_b      <= b;
                r_cnt       <= r_cnt + 16'd1;
            end

            if (w_clear) begin
                r_cnt      <= '0;
                r_s1_valid <= 1'b0;
                sum_ed     <= '0;
                err_count  <= '0;
                max_ed     <= '0;
                max_a      <= '0;
                max_b      <= '0;
            end else if (r_s1_valid) begin
                sum_ed    <= w_sum_next;
                err_count <= err_count + 16'(w_ed != 16'd0);
                if (w_ed > max_ed) begin
                    max_ed <= w_ed;
                    max_a  <= r_s1_a;
                    max_b  <= r_s1_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Scoreboarded random and directed runs of approx_mult_error_monitor against a plain-arithmetic model.
module tb_approx_mult_error_monitor;

    localparam int N     = 4;
    localparam int SUM_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [15:0]      approx_prod;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] sum_ed;
    logic [15:0]      err_count;
    logic [15:0]      max_ed;
    logic [7:0]       max_a;
    logic [7:0]       max_b;
    logic             res_valid;
    logic             res_ready;

    approx_mult_error_monitor #(.SAMPLE_CNT(N), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .a(a), .b(b), .approx_prod(approx_prod), .in_valid(in_valid), .in_ready(in_ready),
        .sum_ed(sum_ed), .err_count(err_count), .max_ed(max_ed), .max_a(max_a), .max_b(max_b),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        int     cnt;
        int     med;
        int     ma;
        int     mb;
    } exp_t;

    exp_t exp_q[$];
    int   sa[$];
    int   sb[$];
    int   sp[$];
    int   ta[N];
    int   tbv[N];
    int   tp[N];
    int   errors = 0;
    int   checks = 0;

    function automatic void check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: statistics straight from the list of accepted samples.
    function automatic exp_t model();
        exp_t e;
        e.sum = 0; e.cnt = 0; e.med = 0; e.ma = 0; e.mb = 0;
        foreach (sa[i]) begin
            int ed;
            ed = sa[i] * sb[i] - sp[i];
            if (ed < 0) ed = -ed;
            e.sum += ed;
            if (ed != 0) e.cnt++;
            if (ed > e.med) begin
                e.med = ed; e.ma = sa[i]; e.mb = sb[i];
            end
        end
        if (e.sum > (longint'(1) << SUM_W) - 1) e.sum = (longint'(1) << SUM_W) - 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum_ed", sum_ed, e.sum);
                check("err_count", err_count, e.cnt);
                check("max_ed", max_ed, e.med);
                check("max_a", max_a, e.ma);
                check("max_b", max_b, e.mb);
            end
        end
    end

    task automatic send(input int ia, input int ib, input int ip, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            in_valid    = 1'b0;
            a           = 8'($urandom);
            b           = 8'($urandom);
            approx_prod = 16'($urandom);
            start       = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start       = 1'b0;
        a           = 8'(ia);
        b           = 8'(ib);
        approx_prod = 16'(ip);
        in_valid    = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            sa.push_back(ia); sb.push_back(ib); sp.push_back(ip);
        end
    endtask

    task automatic begin_run();
        sa.delete(); sb.delete(); sp.delete();
        @(negedge clk);
        in_valid    = 1'b1;
        a           = 8'($urandom);
        b           = 8'($urandom);
        approx_prod = 16'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, 1);
    endtask

    task automatic run(input int gapmax, input int hold, input bit start_with_ready);
        exp_t e;
        begin_run();
        for (int i = 0; i < N; i++) send(ta[i], tbv[i], tp[i], $urandom_range(0, gapmax));
        e = model();
        check("res_valid_in_drain", res_valid, 0);
        check("in_ready_in_drain", in_ready, 0);
        check("busy_in_drain", busy, 1);
        @(posedge clk);
        #1;
        check("res_valid_latency", res_valid, 1);
        check("busy_in_done", busy, 0);
        res_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            start       = 1'b1;
            in_valid    = 1'b1;
            a           = 8'($urandom);
            approx_prod = 16'($urandom);
            check("hold_res_valid", res_valid, 1);
            check("hold_sum_ed", sum_ed, e.sum);
            check("hold_err_count", err_count, e.cnt);
            check("hold_max_ed", max_ed, e.med);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        start     = start_with_ready;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        start     = 1'b0;
        check("idle_res_valid", res_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_sum_kept", sum_ed, e.sum);
        check("idle_max_ed_kept", max_ed, e.med);
    endtask

    task automatic fill_random(input int mode);
        for (int i = 0; i < N; i++) begin
            int p;
            ta[i]  = $urandom_range(0, 255);
            tbv[i] = $urandom_range(0, 255);
            p = ta[i] * tbv[i];
            if (mode == 1) p = p + $urandom_range(0, 40) - 20;
            if (mode == 2) p = $urandom_range(0, 65535);
            if (p < 0) p = 0;
            if (p > 65535) p = 65535;
            tp[i] = p;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        a = '0; b = '0; approx_prod = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_sum_ed", sum_ed, 0);
        check("rst_max_ab", {max_a, max_b}, 0);
        @(negedge clk);
        rst = 1'b0;

        // exact products
        ta = '{3, 200, 0, 255}; tbv = '{7, 9, 44, 255};
        tp = '{21, 1800, 0, 65025};
        run(0, 0, 1'b0);
        // mixed errors, including the largest operands
        ta = '{255, 3, 10, 2}; tbv = '{255, 5, 10, 2}; tp = '{65000, 16, 100, 4};
        run(0, 1, 1'b0);
        // equal error distances: earlier sample must be kept
        ta = '{4, 5, 1, 0}; tbv = '{4, 2, 1, 0}; tp = '{14, 8, 1, 0};
        run(0, 0, 1'b0);
        // stalls with start pulses mid-run
        fill_random(1);
        run(3, 2, 1'b0);
        // long hold in DONE, then start together with res_ready
        fill_random(2);
        run(1, 10, 1'b1);

        // reset mid-run after two accepts
        begin_run();
        send(255, 255, 0, 0);
        send(17, 3, 60, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_sum_ed", sum_ed, 0);
        check("midrst_err_count", err_count, 0);
        check("midrst_max", {max_ed, max_a, max_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_still_idle", busy, 0);
        fill_random(1);
        run(1, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            fill_random(r % 3);
            run(3, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
